// File: rtl/spi_adc_master.sv
// SPI master for the external ADC. A start strobe with a 7-bit channel address launches one
// 16-bit mode-0 frame: command {chan, 9'b0} goes out on MOSI, MSB first, while MISO is
// shifted in. The received word and its channel tag are returned with one-cycle eoc/drdy
// strobes.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous reset, active high
//   start_i      start-conversion strobe, sampled every cycle
//   chan_addr_i  channel address, latched with an accepted start
//   busy_o       high while a frame is in progress (through the DONE cycle)
//   overrun_o    one-cycle pulse for each start_i seen while busy
//   eoc_o        one-cycle end-of-conversion pulse
//   drdy_o       one-cycle data-valid pulse, coincident with eoc_o
//   data_o       last converted word, held between frames
//   chan_o       channel of data_o
//   spi_sclk_o   SPI clock, idles low
//   spi_cs_no    chip select, active low
//   spi_mosi_o   command bit, MSB first
//   spi_miso_i   ADC data, MSB first
module spi_adc_master #(
  parameter int unsigned CLK_DIV  = 4,  // clk_i cycles per SCLK half-period
  parameter int unsigned CS_SETUP = 2,  // CS low to first SCLK phase
  parameter int unsigned CS_HOLD  = 4   // CS high after last SCLK fall, before DONE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [6:0]  chan_addr_i,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        eoc_o,
  output logic        drdy_o,
  output logic [15:0] data_o,
  output logic [6:0]  chan_o,
  output logic        spi_sclk_o,
  output logic        spi_cs_no,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  // One shared counter times SETUP, each SCLK half-period and HOLD.
  localparam int unsigned MaxSd  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned CntMax = (MaxSd > CS_HOLD) ? MaxSd : CS_HOLD;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP - 1);
  localparam logic [CntW-1:0] HalfLast  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(CS_HOLD - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      bit_cnt_q;
  logic [14:0]     tx_q;       // command bits still to be sent after the one on MOSI
  logic [15:0]     rx_q;
  logic [6:0]      chan_lat_q;
  logic            busy_q, overrun_q, eoc_q, drdy_q;
  logic            sclk_q, cs_n_q, mosi_q;
  logic [15:0]     data_q;
  logic [6:0]      chan_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      chan_lat_q <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      eoc_q      <= 1'b0;
      drdy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      data_q     <= '0;
      chan_q     <= '0;
    end else begin
      overrun_q <= start_i & busy_q;
      eoc_q     <= 1'b0;
      drdy_q    <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            chan_lat_q <= chan_addr_i;
            mosi_q     <= chan_addr_i[6];
            tx_q       <= {chan_addr_i[5:0], 9'b0};
            cs_n_q     <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            state_q    <= StSetup;
          end
        end

        StSetup: begin
          if (cnt_q == SetupLast) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= StShift;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StShift: begin
          if (cnt_q == HalfLast) begin
            cnt_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // Falling edge: sample MISO and advance MOSI together.
              sclk_q <= 1'b0;
              rx_q   <= {rx_q[14:0], spi_miso_i};
              tx_q   <= {tx_q[13:0], 1'b0};
              if (bit_cnt_q == 4'd15) begin
                mosi_q  <= 1'b0;
                cs_n_q  <= 1'b1;
                state_q <= StHold;
              end else begin
                mosi_q    <= tx_q[14];
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StHold: begin
          if (cnt_q == HoldLast) begin
            cnt_q   <= '0;
            eoc_q   <= 1'b1;
            drdy_q  <= 1'b1;
            data_q  <= rx_q;
            chan_q  <= chan_lat_q;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          busy_q  <= 1'b0;
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign overrun_o  = overrun_q;
  assign eoc_o      = eoc_q;
  assign drdy_o     = drdy_q;
  assign data_o     = data_q;
  assign chan_o     = chan_q;
  assign spi_sclk_o = sclk_q;
  assign spi_cs_no  = cs_n_q;
  assign spi_mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_adc_master.sv
// Bench for spi_adc_master: one instance with default timing (A) and one with
// CLK_DIV=CS_SETUP=CS_HOLD=1 (B), each with a behavioural ADC slave. Expected
// (channel, word) pairs are queued when a start is driven and compared at eoc.
module tb_spi_adc_master;

  localparam time Tclk = 10;

  typedef struct packed {
    logic [6:0]  chan;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic        a_start, a_busy, a_ov, a_eoc, a_drdy, a_sclk, a_cs_n, a_mosi, a_miso;
  logic [6:0]  a_chan, a_chano;
  logic [15:0] a_data;
  logic        b_start, b_busy, b_ov, b_eoc, b_drdy, b_sclk, b_cs_n, b_mosi, b_miso;
  logic [6:0]  b_chan, b_chano;
  logic [15:0] b_data;

  int checks = 0;
  int failures = 0;

  exp_t sb_a[$];
  exp_t sb_b[$];

  logic [15:0] a_slv_word = '0, a_sh = '0, b_slv_word = '0, b_sh = '0;
  logic [15:0] a_mosi_cap = '0;
  int          a_rises = 0;
  int          a_eoc_cnt = 0, a_ov_cnt = 0;
  time         t_cs_fall, t_rise1, t_rise2, t_fall1, t_cs_rise, t_eoc, t_start;

  spi_adc_master u_dut_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (a_start),
    .chan_addr_i(a_chan),
    .busy_o     (a_busy),
    .overrun_o  (a_ov),
    .eoc_o      (a_eoc),
    .drdy_o     (a_drdy),
    .data_o     (a_data),
    .chan_o     (a_chano),
    .spi_sclk_o (a_sclk),
    .spi_cs_no  (a_cs_n),
    .spi_mosi_o (a_mosi),
    .spi_miso_i (a_miso)
  );

  spi_adc_master #(
    .CLK_DIV (1),
    .CS_SETUP(1),
    .CS_HOLD (1)
  ) u_dut_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (b_start),
    .chan_addr_i(b_chan),
    .busy_o     (b_busy),
    .overrun_o  (b_ov),
    .eoc_o      (b_eoc),
    .drdy_o     (b_drdy),
    .data_o     (b_data),
    .chan_o     (b_chano),
    .spi_sclk_o (b_sclk),
    .spi_cs_no  (b_cs_n),
    .spi_mosi_o (b_mosi),
    .spi_miso_i (b_miso)
  );

  initial forever #(Tclk / 2) clk = ~clk;

  // ADC slave A: MSB presented at CS fall, next bit shortly after each SCLK fall.
  always @(negedge a_cs_n) begin
    a_sh = a_slv_word;
    a_miso = a_sh[15];
    t_cs_fall = $time;
    a_rises = 0;
    a_mosi_cap = '0;
  end
  always @(posedge a_sclk) begin
    if (!a_cs_n) begin
      a_mosi_cap = {a_mosi_cap[14:0], a_mosi};
      a_rises++;
      if (a_rises == 1) t_rise1 = $time;
      if (a_rises == 2) t_rise2 = $time;
    end
  end
  always @(negedge a_sclk) begin
    if (!a_cs_n && a_rises == 1) t_fall1 = $time;
    #1;
    a_sh = {a_sh[14:0], 1'b0};
    a_miso = a_sh[15];
  end
  always @(posedge a_cs_n) t_cs_rise = $time;
  always @(posedge a_eoc) t_eoc = $time;
  always @(negedge clk) begin
    if (a_eoc) a_eoc_cnt++;
    if (a_ov) a_ov_cnt++;
  end

  // ADC slave B
  always @(negedge b_cs_n) begin
    b_sh = b_slv_word;
    b_miso = b_sh[15];
  end
  always @(negedge b_sclk) begin
    #1;
    b_sh = {b_sh[14:0], 1'b0};
    b_miso = b_sh[15];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the start edge E0.
  task automatic start_frame(input bit sel, input logic [6:0] ch, input logic [15:0] w);
    if (sel) begin
      b_slv_word = w; b_chan = ch; b_start = 1'b1; sb_b.push_back({ch, w});
    end else begin
      a_slv_word = w; a_chan = ch; a_start = 1'b1; sb_a.push_back({ch, w});
    end
    @(posedge clk);
    t_start = $time;
    #1;
    // Scramble the address to show it is latched.
    if (sel) begin b_start = 1'b0; b_chan = ~ch; end
    else begin a_start = 1'b0; a_chan = ~ch; end
  endtask

  task automatic wait_eoc(input bit sel, input int lat, input string tag);
    bit   ok = 1'b0;
    int   n;
    exp_t e;
    for (n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (sel ? b_eoc : a_eoc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk({tag, "_eoc_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_latency"}, 32'(n), 32'(lat));
      chk({tag, "_drdy"}, 32'(sel ? b_drdy : a_drdy), 32'd1);
      if ((sel ? sb_b.size() : sb_a.size()) == 0) begin
        chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sel ? sb_b.pop_front() : sb_a.pop_front();
        chk({tag, "_data"}, 32'(sel ? b_data : a_data), 32'(e.data));
        chk({tag, "_chan"}, 32'(sel ? b_chano : a_chano), 32'(e.chan));
      end
    end
  endtask

  // One edge after eoc: strobes gone, back to idle.
  task automatic tail(input bit sel, input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_eoc_low"}, 32'(sel ? b_eoc : a_eoc), 32'd0);
    chk({tag, "_drdy_low"}, 32'(sel ? b_drdy : a_drdy), 32'd0);
    chk({tag, "_busy_low"}, 32'(sel ? b_busy : a_busy), 32'd0);
  endtask

  initial begin
    time t_prev;
    int  ov0, e0;

    rst = 1'b1;
    a_start = 1'b0; a_chan = '0; a_miso = 1'b0;
    b_start = 1'b0; b_chan = '0; b_miso = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(a_cs_n), 32'd1);
    chk("rst_sclk", 32'(a_sclk), 32'd0);
    chk("rst_mosi", 32'(a_mosi), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_overrun", 32'(a_ov), 32'd0);
    chk("rst_eoc", 32'(a_eoc), 32'd0);
    chk("rst_drdy", 32'(a_drdy), 32'd0);
    chk("rst_data", 32'(a_data), 32'd0);
    chk("rst_chan", 32'(a_chano), 32'd0);
    chk("rst_b_cs_n", 32'(b_cs_n), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic frame and timing
    start_frame(1'b0, 7'h1E, 16'hA5C3);
    chk("f1_busy", 32'(a_busy), 32'd1);
    chk("f1_cs_low", 32'(a_cs_n), 32'd0);
    wait_eoc(1'b0, 134, "f1");
    chk("f1_mosi", 32'(a_mosi_cap), 32'h3C00);
    chk("f1_rises", 32'(a_rises), 32'd16);
    chk("f1_cs_to_rise", 32'((t_rise1 - t_cs_fall) / Tclk), 32'd6);
    chk("f1_sclk_high", 32'((t_fall1 - t_rise1) / Tclk), 32'd4);
    chk("f1_sclk_low", 32'((t_rise2 - t_fall1) / Tclk), 32'd4);
    chk("f1_cs_hold", 32'((t_eoc - t_cs_rise) / Tclk), 32'd4);
    tail(1'b0, "f1");
    repeat (5) @(posedge clk);
    #1;
    chk("f1_data_held", 32'(a_data), 32'hA5C3);
    chk("f1_chan_held", 32'(a_chano), 32'h1E);

    // Back-to-back channel sequence
    start_frame(1'b0, 7'h17, 16'h1111);
    t_prev = t_start;
    wait_eoc(1'b0, 134, "seq1");
    tail(1'b0, "seq1");
    start_frame(1'b0, 7'h1E, 16'h2222);
    chk("seq_period1", 32'((t_start - t_prev) / Tclk), 32'd136);
    t_prev = t_start;
    wait_eoc(1'b0, 134, "seq2");
    tail(1'b0, "seq2");
    start_frame(1'b0, 7'h1F, 16'h3333);
    chk("seq_period2", 32'((t_start - t_prev) / Tclk), 32'd136);
    wait_eoc(1'b0, 134, "seq3");
    tail(1'b0, "seq3");

    // Overrun: start mid-frame and during DONE
    ov0 = a_ov_cnt;
    e0 = a_eoc_cnt;
    start_frame(1'b0, 7'h2A, 16'h5A5A);
    repeat (49) @(posedge clk);
    #1;
    a_start = 1'b1; a_chan = 7'h01;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    chk("ov_mid_pulse", 32'(a_ov), 32'd1);
    @(posedge clk);
    #1;
    chk("ov_mid_clear", 32'(a_ov), 32'd0);
    wait_eoc(1'b0, 83, "ov");
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    chk("ov_done_pulse", 32'(a_ov), 32'd1);
    chk("ov_busy_fall", 32'(a_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("ov_count", 32'(a_ov_cnt - ov0), 32'd2);
    chk("ov_eoc_count", 32'(a_eoc_cnt - e0), 32'd1);
    chk("ov_not_restarted", 32'(a_busy), 32'd0);

    // Asynchronous reset mid-frame
    start_frame(1'b0, 7'h33, 16'hBEEF);
    void'(sb_a.pop_back());  // aborted frame never completes
    repeat (69) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cs_n", 32'(a_cs_n), 32'd1);
    chk("arst_sclk", 32'(a_sclk), 32'd0);
    chk("arst_busy", 32'(a_busy), 32'd0);
    chk("arst_data", 32'(a_data), 32'd0);
    e0 = a_eoc_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    chk("arst_no_eoc", 32'(a_eoc_cnt - e0), 32'd0);
    chk("arst_data_kept", 32'(a_data), 32'd0);
    start_frame(1'b0, 7'h0C, 16'h8001);
    wait_eoc(1'b0, 134, "post_rst");
    tail(1'b0, "post_rst");

    // Minimum timing parameters
    start_frame(1'b1, 7'h05, 16'hFFFF);
    wait_eoc(1'b1, 34, "min_ffff");
    tail(1'b1, "min_ffff");
    start_frame(1'b1, 7'h41, 16'h0001);
    wait_eoc(1'b1, 34, "min_0001");
    tail(1'b1, "min_0001");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
